// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: the NOP encoding and the MEM/WB FSM state encoding.
package wisc_pkg;

   localparam logic [15:0] WISC_NOP = 16'h0800;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAIT   = 2'b01,
      HALTED = 2'b10
   } state_t;

endpackage

// File: rtl/memwb_field_reg.sv
// Parameterized-width pipeline field register with synchronous reset value and load enable.
module memwb_field_reg #(
   parameter int unsigned         W       = 16,
   parameter logic [W-1:0]        RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (rst)       q_o <= RST_VAL;
      else if (en_i) q_o <= d_i;
   end

endmodule

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: holds the pipeline during cache misses, inserts writeback bubbles,
// latches halt/error stickily and counts stall cycles.
module mem_wb_latch
   import wisc_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = WISC_NOP,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic             mem_access,
   input  logic             Done,
   input  logic [15:0]      writeData_in,
   input  logic             RegWrite_in,
   input  logic [2:0]       writeReg_in,
   input  logic [15:0]      pcPlus2_in,
   input  logic [15:0]      instruction_in,
   input  logic             Halt_in,
   input  logic             err_in,
   output logic             stall_pipe,
   output logic             wb_valid,
   output logic             RegWrite_out,
   output logic [2:0]       writeReg_out,
   output logic [15:0]      writeData_out,
   output logic [15:0]      pcPlus2_out,
   output logic [15:0]      instruction_out,
   output logic             Halt_out,
   output logic             err_out,
   output logic [CNT_W-1:0] stall_cycles
);

   state_t           state_q, state_d;
   logic             wb_valid_q, halt_q, err_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             req, cap_valid;

   always_comb begin
      req        = valid_in & mem_access & ~halt_q;
      stall_pipe = 1'b0;
      cap_valid  = 1'b0;
      state_d    = state_q;
      unique case (state_q)
         IDLE: begin
            stall_pipe = req & ~Done;
            cap_valid  = valid_in & ~halt_q & (~mem_access | Done);
            if (req & ~Done) state_d = WAIT;
         end
         WAIT: begin
            // Upstream holds its inputs while stalled, so the Done cycle sees the original request.
            stall_pipe = ~Done;
            cap_valid  = Done;
            if (Done) state_d = IDLE;
         end
         HALTED: begin
         end
         default: state_d = IDLE;
      endcase
      if (cap_valid & Halt_in) state_d = HALTED;
      if (rst) stall_pipe = 1'b0;
      stall_cnt_d = (stall_pipe && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wb_valid_q  <= 1'b0;
         halt_q      <= 1'b0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wb_valid_q  <= cap_valid;
         halt_q      <= halt_q | (cap_valid & Halt_in);
         err_q       <= err_q | (cap_valid & err_in);
         stall_cnt_q <= stall_cnt_d;
      end
   end

   memwb_field_reg #(.W(1), .RST_VAL(1'b0)) u_regwrite (
      .clk(clk), .rst(rst), .en_i(1'b1), .d_i(RegWrite_in & cap_valid), .q_o(RegWrite_out));

   memwb_field_reg #(.W(3), .RST_VAL(3'd0)) u_writereg (
      .clk(clk), .rst(rst), .en_i(cap_valid), .d_i(writeReg_in), .q_o(writeReg_out));

   memwb_field_reg #(.W(16), .RST_VAL(16'h0000)) u_writedata (
      .clk(clk), .rst(rst), .en_i(cap_valid), .d_i(writeData_in), .q_o(writeData_out));

   memwb_field_reg #(.W(16), .RST_VAL(16'h0000)) u_pcplus2 (
      .clk(clk), .rst(rst), .en_i(cap_valid), .d_i(pcPlus2_in), .q_o(pcPlus2_out));

   memwb_field_reg #(.W(16), .RST_VAL(NOP_INSTR)) u_instr (
      .clk(clk), .rst(rst), .en_i(1'b1),
      .d_i(cap_valid ? instruction_in : NOP_INSTR), .q_o(instruction_out));

   assign wb_valid     = wb_valid_q;
   assign Halt_out     = halt_q;
   assign err_out      = err_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/mem_wb_latch.md
# mem_wb_latch

Pipeline register between the memory stage and the writeback stage of the 5-stage WISC pipeline. It captures the memory stage's results, including the writeback data, destination register, and control and status bits. While the cache-based data memory is busy, it holds the pipeline and inserts bubbles into writeback. It latches halt and error conditions stickily, and counts memory stall cycles for performance reporting.

## Interface
Parameters:
- NOP_INSTR, 16'h0800: instruction word presented in writeback for bubbles and after reset.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  memory stage holds a real instruction.
- mem_access  in  1  that instruction uses data memory (DMemEn).
- Done  in  1  data memory finished the current access; DataOut is valid this cycle.
- writeData_in  in  16  writeback value from the memory stage (read data or ALU result).
- RegWrite_in  in  1  instruction writes the register file.
- writeReg_in  in  3  destination register.
- pcPlus2_in  in  16  PC+2 of the instruction.
- instruction_in  in  16  instruction word.
- Halt_in  in  1  instruction is HALT (DMemDump).
- err_in  in  1  memory-stage error (misalignment or X data).
- stall_pipe  out  1  freezes the PC and all upstream pipeline registers this cycle.
- wb_valid  out  1  the writeback stage holds a real instruction.
- RegWrite_out  out  1  register-file write enable; already gated by wb_valid.
- writeReg_out  out  3  registered destination register.
- writeData_out  out  16  registered writeback value.
- pcPlus2_out  out  16  registered PC+2.
- instruction_out  out  16  registered instruction word.
- Halt_out  out  1  sticky; the processor has halted.
- err_out  out  1  sticky error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_pipe high.

## Operation
The FSM has three states: IDLE, WAIT and HALTED. Define `req = valid_in & mem_access & ~Halt_out`.

IDLE:
- If `req & ~Done`: go to WAIT. Set stall_pipe=1. Capture a bubble.
- If `req & Done` (cache hit): capture the inputs with wb_valid=1 and stay in IDLE. stall_pipe=0.
- If `valid_in & ~mem_access`: capture the inputs with wb_valid=1.
- If `~valid_in`: capture a bubble.

WAIT:
- While `~Done`: stall_pipe=1 and capture a bubble.
- On Done: capture the inputs with wb_valid=1, set stall_pipe=0, and return to IDLE.

Halt and error handling:
- Capturing a valid instruction with Halt_in=1 sets Halt_out and moves the FSM to HALTED.
- HALTED is terminal until rst. In HALTED, only bubbles are captured and stall_pipe stays 0.
- Capturing a valid instruction with err_in=1 sets err_out. err_out stays set until rst.

Capture definitions:
- A bubble sets wb_valid=0, RegWrite_out=0, instruction_out=NOP_INSTR. writeReg_out, writeData_out and pcPlus2_out keep their previous values.
- RegWrite_out = RegWrite_in & captured-valid.

stall_cycles:
- Increments by 1 on every cycle with stall_pipe=1.
- Saturates at all-ones and never wraps.

## Timing
- Every output except stall_pipe is registered, with a capture latency of 1 cycle.
- stall_pipe is combinational from state, valid_in, mem_access, Done and Halt_out. It must settle within the cycle.
- Reset values:
  - state=IDLE
  - wb_valid=0, RegWrite_out=0
  - writeReg_out=0, writeData_out=0, pcPlus2_out=0
  - instruction_out=NOP_INSTR
  - Halt_out=0, err_out=0
  - stall_cycles=0
  - stall_pipe=0 while rst is high
- rst mid-WAIT: the FSM returns to IDLE on the next edge. The pending access is abandoned. No capture occurs.
- The upstream stage holds its inputs stable for as long as stall_pipe=1. This block does not buffer a second request.
- Done asserted in IDLE without req: ignored.
- Halt_in and err_in on the same captured instruction: both sticky flags set on the same edge.
- Halt_in on a memory access: it is honoured only when that access completes.

## Structure
- Shared package `wisc_pkg` holds:
  - NOP_INSTR encoding.
  - FSM state encodings: IDLE=2'b00, WAIT=2'b01, HALTED=2'b10.
- One sub-module, `memwb_field_reg`: a parameterized-width register with synchronous reset value and load enable. It is instantiated for each field.

## Test plan
- ALU op flow: valid_in=1, mem_access=0, writeData_in=16'h1234, writeReg_in=3 → next cycle wb_valid=1, RegWrite_out=1, writeData_out=16'h1234, stall_pipe=0 throughout.
- Cache hit load: req with Done=1 in the same cycle, data 16'hBEEF → no stall, writeData_out=16'hBEEF after 1 cycle, stall_cycles stays 0.
- Miss load: req with Done low for 4 cycles then high → stall_pipe=1 for exactly 4 cycles, 4 bubbles (instruction_out=16'h0800), captured once on the Done cycle, stall_cycles=4.
- HALT: valid Halt_in=1 with a non-memory op → Halt_out=1 next cycle and stays set. Later valid inputs produce only bubbles. A later rst clears Halt_out.
- Error and reset: err_in=1 captured → err_out sticky. Assert rst mid-WAIT → all outputs at reset values on the next edge, state=IDLE.
- Counter saturation: CNT_W=4 with 20 stall cycles → stall_cycles=4'hF with no wrap.
